// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states, size and legality helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        WAIT0 = 3'd2,
        REQ1  = 3'd3,
        WAIT1 = 3'd4,
        RESP  = 3'd5,
        ERR   = 3'd6
    } lsu_state_t;

    // Access size in bytes; bit 2 of funct3 only selects the extension mode.
    function automatic logic [2:0] size_of(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   size_of = 3'd1;
            2'b01:   size_of = 3'd2;
            default: size_of = 3'd4;
        endcase
    endfunction

    // Stores have no unsigned variants; loads allow the five RV32I encodings.
    function automatic logic is_legal(input logic we, input logic [2:0] funct3);
        if (we) begin
            is_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end else begin
            is_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                       (funct3 == F3_BU) || (funct3 == F3_HU);
        end
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response and data-memory port bundle; master is the LSU side, slave the surrounding core/memory.
interface lsu_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              mem_req;
    logic              mem_gnt;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and write shifts for both beats, load gather and extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata0,
    input  logic [31:0] i_rdata1,
    output logic [3:0]  o_be0_c,
    output logic [3:0]  o_be1_c,
    output logic [31:0] o_wdata0_c,
    output logic [31:0] o_wdata1_c,
    output logic        o_split_c,
    output logic [31:0] o_rdata_c
);
    logic [2:0]  w_size;
    logic [7:0]  w_mask;
    logic [63:0] w_wshift;
    logic [63:0] w_rshift;
    logic [31:0] w_raw;
    logic        w_sgn;

    // Two-word view: low half is beat 0, high half is beat 1.
    always_comb begin
        w_size     = size_of(i_funct3);
        w_mask     = ((8'd1 << w_size) - 8'd1) << i_off;
        o_be0_c    = w_mask[3:0];
        o_be1_c    = w_mask[7:4];
        o_split_c  = |w_mask[7:4];
        w_wshift   = {32'd0, i_wdata} << {i_off, 3'b000};
        o_wdata0_c = w_wshift[31:0];
        o_wdata1_c = w_wshift[63:32];
        w_rshift   = {i_rdata1, i_rdata0} >> {i_off, 3'b000};
        w_raw      = w_rshift[31:0];
        w_sgn      = ~i_funct3[2];
        case (w_size)
            3'd1:    o_rdata_c = {{24{w_sgn & w_raw[7]}}, w_raw[7:0]};
            3'd2:    o_rdata_c = {{16{w_sgn & w_raw[15]}}, w_raw[15:0]};
            default: o_rdata_c = w_raw;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one request, issues one or two memory beats, returns a response pulse.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic clk,
    input  logic rst_n,
    lsu_if.master bus
);
    lsu_state_t        r_state;
    lsu_state_t        w_state_nxt;

    logic              r_we;
    logic [2:0]        r_f3;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata0;

    logic              r_req_ready;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [3:0]        r_mem_be;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;

    logic              w_idle;
    logic [2:0]        w_f3;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] w_word;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata0;
    logic [3:0]        w_be0;
    logic [3:0]        w_be1;
    logic [DATA_W-1:0] w_wd0;
    logic [DATA_W-1:0] w_wd1;
    logic              w_split;
    logic [DATA_W-1:0] w_ld;

    logic              w_mem_req_nxt;
    logic              w_mem_we_nxt;
    logic [3:0]        w_mem_be_nxt;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic [DATA_W-1:0] w_mem_wdata_nxt;
    logic              w_rsp_valid_nxt;
    logic [DATA_W-1:0] w_rsp_rdata_nxt;
    logic              w_rsp_err_nxt;

    // In IDLE the lane logic looks at the live request so beat 0 can be registered at the accept edge.
    always_comb begin
        w_idle   = (r_state == IDLE);
        w_f3     = w_idle ? bus.req_funct3 : r_f3;
        w_addr   = w_idle ? bus.req_addr   : r_addr;
        w_wdata  = w_idle ? bus.req_wdata  : r_wdata;
        w_word   = {w_addr[ADDR_W-1:2], 2'b00};
        w_rdata0 = (r_state == WAIT0) ? bus.mem_rdata : r_rdata0;
    end

    lsu_align u_align (
        .i_funct3   (w_f3),
        .i_off      (w_addr[1:0]),
        .i_wdata    (w_wdata),
        .i_rdata0   (w_rdata0),
        .i_rdata1   (bus.mem_rdata),
        .o_be0_c    (w_be0),
        .o_be1_c    (w_be1),
        .o_wdata0_c (w_wd0),
        .o_wdata1_c (w_wd1),
        .o_split_c  (w_split),
        .o_rdata_c  (w_ld)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus next values of every registered output.
    always_comb begin
        w_state_nxt     = r_state;
        w_mem_we_nxt    = 1'b0;
        w_mem_be_nxt    = 4'd0;
        w_mem_addr_nxt  = '0;
        w_mem_wdata_nxt = '0;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (!is_legal(bus.req_we, bus.req_funct3)) begin
                        w_state_nxt = ERR;
                    end else begin
                        w_state_nxt     = REQ0;
                        w_mem_we_nxt    = bus.req_we;
                        w_mem_be_nxt    = w_be0;
                        w_mem_addr_nxt  = w_word;
                        w_mem_wdata_nxt = w_wd0;
                    end
                end
            end
            REQ0, REQ1: begin
                if (bus.mem_gnt) begin
                    w_state_nxt = (r_state == REQ0) ? WAIT0 : WAIT1;
                end else begin
                    w_mem_we_nxt    = r_mem_we;
                    w_mem_be_nxt    = r_mem_be;
                    w_mem_addr_nxt  = r_mem_addr;
                    w_mem_wdata_nxt = r_mem_wdata;
                end
            end
            WAIT0: begin
                if (bus.mem_rvalid) begin
                    if (w_split) begin
                        w_state_nxt     = REQ1;
                        w_mem_we_nxt    = r_we;
                        w_mem_be_nxt    = w_be1;
                        w_mem_addr_nxt  = w_word + ADDR_W'(4);
                        w_mem_wdata_nxt = w_wd1;
                    end else begin
                        w_state_nxt = RESP;
                    end
                end
            end
            WAIT1: begin
                if (bus.mem_rvalid) begin
                    w_state_nxt = RESP;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_mem_req_nxt   = (w_state_nxt == REQ0) || (w_state_nxt == REQ1);
        w_rsp_valid_nxt = (w_state_nxt == RESP) || (w_state_nxt == ERR);
        w_rsp_err_nxt   = (w_state_nxt == ERR);
        w_rsp_rdata_nxt = ((w_state_nxt == RESP) && !r_we) ? w_ld : '0;
    end

    // Request capture and beat-0 read data holding for split loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we     <= 1'b0;
            r_f3     <= 3'd0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
        end else begin
            if (w_idle && bus.req_valid) begin
                r_we    <= bus.req_we;
                r_f3    <= bus.req_funct3;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
            end
            if ((r_state == WAIT0) && bus.mem_rvalid) begin
                r_rdata0 <= bus.mem_rdata;
            end
        end
    end

    // Registered outputs; reset clears the memory request immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_ready <= 1'b1;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'd0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_req_ready <= (w_state_nxt == IDLE);
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_be    <= w_mem_be_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: aligned, sub-word, split, error, stall and reset cases.
module tb_lsu_ctrl;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    lsu_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serve one memory beat after stalling the grant for the given number of cycles.
    task automatic beat(input string tag, input logic we, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] rd, input int stall);
        for (int i = 0; i < stall; i++) begin
            chk({tag, " stall req"}, 32'(bus.mem_req), 32'd1);
            chk({tag, " stall addr"}, bus.mem_addr, a);
            chk({tag, " stall be"}, 32'(bus.mem_be), 32'(be));
            chk({tag, " stall rsp"}, 32'(bus.rsp_valid), 32'd0);
            tick();
        end
        chk({tag, " req"}, 32'(bus.mem_req), 32'd1);
        chk({tag, " we"}, 32'(bus.mem_we), 32'(we));
        chk({tag, " addr"}, bus.mem_addr, a);
        chk({tag, " be"}, 32'(bus.mem_be), 32'(be));
        if (we) chk({tag, " wdata"}, bus.mem_wdata & lanes(be), wd & lanes(be));
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        chk({tag, " wait req"}, 32'(bus.mem_req), 32'd0);
        chk({tag, " wait rsp"}, 32'(bus.rsp_valid), 32'd0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rd;
        tick();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h5A5A_5A5A;
    endtask

    // Full transaction; the response is checked in the exact cycle it is due.
    task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                        input logic [31:0] a0, input logic [3:0] be0, input logic [31:0] wd0,
                        input logic [31:0] rd0, input logic split,
                        input logic [31:0] a1, input logic [3:0] be1, input logic [31:0] wd1,
                        input logic [31:0] rd1, input logic [31:0] exp_rdata);
        chk({tag, " ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        tick();
        bus.req_valid  = 1'b0;
        bus.req_we     = ~we;
        bus.req_funct3 = 3'b111;
        bus.req_addr   = 32'hFFFF_FFFF;
        bus.req_wdata  = 32'h0;
        chk({tag, " busy"}, 32'(bus.req_ready), 32'd0);
        beat({tag, " b0"}, we, a0, be0, wd0, rd0, stall);
        if (split) beat({tag, " b1"}, we, a1, be1, wd1, rd1, 0);
        chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, " rsp_err"}, 32'(bus.rsp_err), 32'd0);
        chk({tag, " rsp_rdata"}, bus.rsp_rdata, exp_rdata);
        tick();
        chk({tag, " pulse end"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, " ready again"}, 32'(bus.req_ready), 32'd1);
    endtask

    // Illegal funct3: error pulse one cycle after accept, no memory access.
    task automatic err_xact(input string tag, input logic we, input logic [2:0] f3);
        chk({tag, " ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = 32'h0000_0100;
        tick();
        bus.req_valid = 1'b0;
        chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, " rsp_err"}, 32'(bus.rsp_err), 32'd1);
        chk({tag, " rsp_rdata"}, bus.rsp_rdata, 32'd0);
        chk({tag, " mem_req"}, 32'(bus.mem_req), 32'd0);
        tick();
        chk({tag, " pulse end"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, " ready again"}, 32'(bus.req_ready), 32'd1);
        chk({tag, " no mem_req"}, 32'(bus.mem_req), 32'd0);
    endtask

    initial begin
        n_pass         = 0;
        n_total        = 0;
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'd0;

        repeat (2) tick();
        chk("rst req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst mem_be", 32'(bus.mem_be), 32'd0);
        chk("rst mem_addr", bus.mem_addr, 32'd0);
        chk("rst mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst rsp_err", 32'(bus.rsp_err), 32'd0);
        rst_n = 1'b1;
        tick();

        xact("SW", 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 32'h100, 4'b1111, 32'hDEAD_BEEF,
             32'h0, 1'b0, 32'h0, 4'b0, 32'h0, 32'h0, 32'h0);
        xact("SB", 1'b1, 3'b000, 32'h103, 32'h0000_00A5, 0, 32'h100, 4'b1000, 32'hA500_0000,
             32'h0, 1'b0, 32'h0, 4'b0, 32'h0, 32'h0, 32'h0);
        xact("LB101", 1'b0, 3'b000, 32'h101, 32'h0, 0, 32'h100, 4'b0010, 32'h0,
             32'h80FF_7F00, 1'b0, 32'h0, 4'b0, 32'h0, 32'h0, 32'h0000_007F);
        xact("LB103", 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h100, 4'b1000, 32'h0,
             32'h80FF_7F00, 1'b0, 32'h0, 4'b0, 32'h0, 32'h0, 32'hFFFF_FF80);
        xact("LBU103", 1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h100, 4'b1000, 32'h0,
             32'h80FF_7F00, 1'b0, 32'h0, 4'b0, 32'h0, 32'h0, 32'h0000_0080);
        xact("LHU102", 1'b0, 3'b101, 32'h102, 32'h0, 0, 32'h100, 4'b1100, 32'h0,
             32'h80FF_7F00, 1'b0, 32'h0, 4'b0, 32'h0, 32'h0, 32'h0000_80FF);
        xact("LH102", 1'b0, 3'b001, 32'h102, 32'h0, 0, 32'h100, 4'b1100, 32'h0,
             32'h80FF_7F00, 1'b0, 32'h0, 4'b0, 32'h0, 32'h0, 32'hFFFF_80FF);
        xact("LWsplit", 1'b0, 3'b010, 32'h106, 32'h0, 0, 32'h104, 4'b1100, 32'h0,
             32'hBBAA_0000, 1'b1, 32'h108, 4'b0011, 32'h0, 32'h0000_DDCC, 32'hDDCC_BBAA);
        xact("SHsplit", 1'b1, 3'b001, 32'h103, 32'h0000_1234, 0, 32'h100, 4'b1000, 32'h3400_0000,
             32'h0, 1'b1, 32'h104, 4'b0001, 32'h0000_0012, 32'h0, 32'h0);
        err_xact("ERRst", 1'b1, 3'b100);
        err_xact("ERRld", 1'b0, 3'b011);
        xact("LWstall", 1'b0, 3'b010, 32'h200, 32'h0, 4, 32'h200, 4'b1111, 32'h0,
             32'h1122_3344, 1'b0, 32'h0, 4'b0, 32'h0, 32'h0, 32'h1122_3344);

        // Reset while a beat is being requested.
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h100;
        tick();
        bus.req_valid = 1'b0;
        chk("rstREQ0 pre mem_req", 32'(bus.mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstREQ0 mem_req", 32'(bus.mem_req), 32'd0);
        chk("rstREQ0 mem_be", 32'(bus.mem_be), 32'd0);
        chk("rstREQ0 ready", 32'(bus.req_ready), 32'd1);
        #1 rst_n = 1'b1;
        tick();

        // Reset while waiting for completion; the late rvalid must be ignored.
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h104;
        tick();
        bus.req_valid = 1'b0;
        bus.mem_gnt   = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstWAIT0 mem_req", 32'(bus.mem_req), 32'd0);
        chk("rstWAIT0 ready", 32'(bus.req_ready), 32'd1);
        #1 rst_n = 1'b1;
        tick();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hCAFE_F00D;
        tick();
        bus.mem_rvalid = 1'b0;
        chk("stale rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("stale mem_req", 32'(bus.mem_req), 32'd0);
        chk("stale ready", 32'(bus.req_ready), 32'd1);
        tick();
        chk("stale rsp_valid later", 32'(bus.rsp_valid), 32'd0);

        xact("LBUpost", 1'b0, 3'b100, 32'h105, 32'h0, 0, 32'h104, 4'b0010, 32'h0,
             32'h0000_9C00, 1'b0, 32'h0, 4'b0, 32'h0, 32'h0, 32'h0000_009C);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

- Load/store unit on the core side of the data-memory port. It initiates the transactions that data memory serves.
- Takes one load or store at a time from the execute/memory stage over a valid/ready handshake, decoded by Funct3 (LB/LH/LW/LBU/LHU/SB/SH/SW).
- Issues word-aligned memory beats with per-byte write enables, splitting word-crossing accesses into two beats.
- Returns a sign- or zero-extended load result, or a store acknowledge, as a one-cycle response pulse.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data width; only 32 is supported (4 byte lanes)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle, can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  instruction bits 14:12
- req_addr  in  ADDR_W  byte address (ALU result)
- req_wdata  in  DATA_W  store data (rs2), LSB-justified
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  extended load result; 0 for stores and errors
- rsp_err  out  1  illegal funct3; valid only with rsp_valid
- mem_req  out  1  memory beat request
- mem_gnt  in  1  beat accepted in the cycle where mem_req && mem_gnt
- mem_we  out  1  beat is a write
- mem_be  out  4  byte-lane enables
- mem_addr  out  ADDR_W  word address, bits 1:0 always 00
- mem_wdata  out  DATA_W  lane-aligned write data
- mem_rvalid  in  1  beat completion (read data or write ack), at least 1 cycle after grant
- mem_rdata  in  DATA_W  read data, valid with mem_rvalid

## Operation
- Handshake and capture:
  - A request is accepted on the edge where req_valid && req_ready.
  - We, funct3, addr and wdata are registered at that edge.
  - req_ready = (state == IDLE).
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000, 001, 010.
  - Anything else gives an error response with no memory access.
- Sizes: byte = 1, half = 2, word = 4 bytes. off = addr[1:0].
- Split rule: an access is split when off + size > 4.
  - Beat 0: word addr[ADDR_W-1:2]; lanes off..3.
  - Beat 1: next word (+4); lanes 0..(off+size-5).
- Write data:
  - Beat 0: wdata << 8*off.
  - Beat 1: wdata >> 8*(4-off).
  - Disabled lanes are don't-care.
- Load assembly:
  - Collect bytes from beat 0 lanes off.. and then beat 1 lanes 0...
  - Extend from bit 8*size-1: sign-extend for LB/LH, zero-extend for LBU/LHU. LW is not extended.
- States and transitions:
  - IDLE: on accept, go to ERR if funct3 is illegal, else REQ0.
  - REQ0: go to WAIT0 on mem_gnt.
  - WAIT0: on mem_rvalid, go to REQ1 if split, else RESP.
  - REQ1: go to WAIT1 on mem_gnt.
  - WAIT1: go to RESP on mem_rvalid.
  - RESP and ERR: go to IDLE unconditionally.
- mem_req is asserted exactly in REQ0 and REQ1.
  - mem_we, mem_be, mem_addr and mem_wdata are driven from registers and held stable while mem_req is high and ungranted.
  - They are 0 outside REQx.
- mem_rvalid outside WAIT0/WAIT1 is ignored.

## Timing
- Reset values:
  - state = IDLE.
  - req_ready = 1, applied immediately on rst_n low.
  - mem_req = 0, mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
- Accept at edge N:
  - mem_req is high in cycle N+1.
  - With mem_gnt in N+1 and mem_rvalid in N+2, rsp_valid is high in N+3.
  - Minimum latency is 3 cycles for unsplit accesses and 5 for split.
- Error: rsp_valid and rsp_err are high in cycle N+1; the next accept is possible at edge N+2.
- Back-to-back: req_ready rises in the cycle after the rsp_valid cycle.
- Each grant stall adds one cycle per cycle of mem_gnt = 0; request fields stay constant.
- rsp_valid has no backpressure. rsp_rdata is registered and stable for its pulse.
- Reset mid-operation:
  - Abort immediately and clear mem_req asynchronously. No response is issued.
  - A stale mem_rvalid after release is ignored in IDLE.

## Structure
- lsu_pkg holds:
  - the funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state enum lsu_state_t;
  - the functions size_of(funct3) and is_legal(we, funct3).
- Sub-module lsu_align is combinational. It generates byte enables and write-data shifts for both beats, and performs load byte gathering plus sign/zero extension.
- lsu_ctrl holds the FSM and all registers.

## Test plan
- SW addr 0x100, wdata 0xDEADBEEF, gnt immediate, rvalid next cycle -> single beat: addr 0x100, be 1111, wdata 0xDEADBEEF, we 1; rsp_valid at N+3, rsp_err 0.
- SB addr 0x103, wdata 0x000000A5 -> be 1000, mem_wdata[31:24] = 0xA5, one beat.
- mem_rdata 0x80FF7F00 with:
  - LB @0x101 -> 0x0000007F
  - LB @0x103 -> 0xFFFFFF80
  - LBU @0x103 -> 0x00000080
  - LHU @0x102 -> 0x000080FF
- LW @0x106 (split):
  - Beat 0: addr 0x104, be 1100, rdata 0xBBAA0000.
  - Beat 1: addr 0x108, be 0011, rdata 0x0000DDCC.
  - Result: rsp_rdata 0xDDCCBBAA at N+5.
- SH @0x103, wdata 0x1234 (split):
  - Beat 0: addr 0x100, be 1000, lane 3 = 0x34.
  - Beat 1: addr 0x104, be 0001, lane 0 = 0x12.
- Error, stall and reset:
  - Store funct3 100 -> rsp_err 1 at N+1, no mem_req.
  - mem_gnt low 4 cycles -> mem_req and all fields stable; rsp delayed 4 cycles.
  - rst_n low in WAIT0 -> mem_req 0 at once; stray rvalid after release produces no rsp_valid.
